// File: rtl/oflow_fsm_write_pkg.sv
// Shared MEM-buffer definitions common to the optical-flow write and read FSMs.
package oflow_fsm_write_pkg;

  localparam int unsigned ADDR_WIDTH                  = 8;
  localparam int unsigned OFFSET_WIDTH                = ADDR_WIDTH;
  localparam int unsigned TOTAL_FRAME_NUM_WIDTH       = 8;
  localparam int unsigned NUM_OF_HISTORY_FRAMES_WIDTH = 4;
  localparam int unsigned NUM_SLOTS                   = 5;
  localparam int unsigned SLOT_WIDTH                  = 3;
  localparam int unsigned DATA_WIDTH                  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StCommit,
    StDone
  } wr_state_e;

  // Slot = frame % history depth; depth 0 acts as 1, and depth is capped at the slot count.
  function automatic int unsigned slot_of(input int unsigned frame, input int unsigned hist,
                                          input int unsigned num_slots);
    int unsigned h;
    h = (hist == 0) ? 1 : hist;
    if (h > num_slots) h = num_slots;
    return frame % h;
  endfunction

endpackage

// File: rtl/oflow_fsm_write_end_ptrs.sv
// oflow_end_pointer_regs: per-slot committed line counts with single-slot load and async clear.
module oflow_end_pointer_regs
  import oflow_fsm_write_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = oflow_fsm_write_pkg::NUM_SLOTS,
  parameter int unsigned ADDR_WIDTH = oflow_fsm_write_pkg::ADDR_WIDTH,
  parameter int unsigned SLOT_WIDTH = oflow_fsm_write_pkg::SLOT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_N,
  input  logic                                 load_i,
  input  logic [SLOT_WIDTH-1:0]                load_slot_i,
  input  logic [ADDR_WIDTH-1:0]                load_val_i,
  output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0] ptrs_o
);

  logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0] ptrs_q, ptrs_d;

  always_comb begin
    ptrs_d = ptrs_q;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (load_i && (load_slot_i == SLOT_WIDTH'(i))) ptrs_d[i] = load_val_i;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) ptrs_q <= '0;
    else          ptrs_q <= ptrs_d;
  end

  assign ptrs_o = ptrs_q;

endmodule

// File: rtl/oflow_fsm_write.sv
// Write-side sequencer of the optical-flow MEM buffer.
// Optional OFLOW_WRITE_OVERFLOW_DROP_EN: accept and drop lines past slot capacity.
module oflow_fsm_write
  import oflow_fsm_write_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = oflow_fsm_write_pkg::NUM_SLOTS,
  parameter int unsigned ADDR_WIDTH      = oflow_fsm_write_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = oflow_fsm_write_pkg::DATA_WIDTH,
  parameter int unsigned FRAME_NUM_WIDTH = oflow_fsm_write_pkg::TOTAL_FRAME_NUM_WIDTH,
  parameter int unsigned HIST_WIDTH      = oflow_fsm_write_pkg::NUM_OF_HISTORY_FRAMES_WIDTH,
  parameter int unsigned SLOT_WIDTH      = oflow_fsm_write_pkg::SLOT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_N,
  input  logic [FRAME_NUM_WIDTH-1:0]           frame_num,
  input  logic [HIST_WIDTH-1:0]                num_of_history_frames,
  input  logic                                 start_write,
  input  logic                                 line_valid,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic                                 frame_end,
  output logic                                 ready_out,
  output logic                                 we,
  output logic [SLOT_WIDTH-1:0]                wr_slot,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0] end_pointers,
`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
  output logic                                 overflow,
  output logic [ADDR_WIDTH-1:0]                dropped_cnt,
`endif
  output logic                                 busy,
  output logic                                 done_write
);

  localparam logic [ADDR_WIDTH-1:0] CntMax = '1;

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic                  we_q, we_d;
  logic [SLOT_WIDTH-1:0] wr_slot_q, wr_slot_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cnt_full, accept, commit;

  assign cnt_full = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    we_d      = 1'b0;
    wr_slot_d = wr_slot_q;
    wr_addr_d = wr_addr_q;
    data_d    = data_q;
    ready_out = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_write) begin
          slot_d  = SLOT_WIDTH'(slot_of(32'(frame_num), 32'(num_of_history_frames), NUM_SLOTS));
          cnt_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
        ready_out = 1'b1;
`else
        ready_out = !cnt_full;
`endif
        accept = line_valid && ready_out;
        // Lines past capacity are only reachable with drop enabled; they never write.
        if (accept && !cnt_full) begin
          we_d      = 1'b1;
          wr_slot_d = slot_q;
          wr_addr_d = cnt_q;
          data_d    = data_in;
          cnt_d     = cnt_q + 1'b1;
        end
        if (frame_end) state_d = StCommit;
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      slot_q    <= '0;
      we_q      <= 1'b0;
      wr_slot_q <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      we_q      <= we_d;
      wr_slot_q <= wr_slot_d;
      wr_addr_q <= wr_addr_d;
      data_q    <= data_d;
    end
  end

  oflow_end_pointer_regs #(
    .NUM_SLOTS  (NUM_SLOTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLOT_WIDTH (SLOT_WIDTH)
  ) u_end_ptrs (
    .clk         (clk),
    .reset_N     (reset_N),
    .load_i      (commit),
    .load_slot_i (slot_q),
    .load_val_i  (cnt_q),
    .ptrs_o      (end_pointers)
  );

`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] drop_q, drop_d;

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if ((state_q == StIdle) && start_write) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (accept && cnt_full) begin
      ovf_d = 1'b1;
      if (drop_q != CntMax) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign overflow    = ovf_q;
  assign dropped_cnt = drop_q;
`endif

  assign we         = we_q;
  assign wr_slot    = wr_slot_q;
  assign wr_addr    = wr_addr_q;
  assign data_out   = data_q;
  assign busy       = (state_q != StIdle);
  assign done_write = (state_q == StDone);

endmodule

// File: tb/tb_oflow_fsm_write.sv
// Randomized bench for oflow_fsm_write against a frame-level reference model.
module tb_oflow_fsm_write;

  localparam int unsigned NS  = 5;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned FW  = 8;
  localparam int unsigned HW  = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned CAP = (1 << AW) - 1;

  logic                         clk = 1'b0;
  logic                         reset_N = 1'b0;
  logic [FW-1:0]                frame_num = '0;
  logic [HW-1:0]                num_of_history_frames = '0;
  logic                         start_write = 1'b0;
  logic                         line_valid = 1'b0;
  logic [DW-1:0]                data_in = '0;
  logic                         frame_end = 1'b0;
  logic                         ready_out, we, busy, done_write;
  logic [SW-1:0]                wr_slot;
  logic [AW-1:0]                wr_addr;
  logic [DW-1:0]                data_out;
  logic [NS-1:0][AW-1:0]        end_pointers;
`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
  logic                         overflow;
  logic [AW-1:0]                dropped_cnt;
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  always #5 clk = ~clk;

  oflow_fsm_write #(
    .NUM_SLOTS       (NS),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .FRAME_NUM_WIDTH (FW),
    .HIST_WIDTH      (HW),
    .SLOT_WIDTH      (SW)
  ) dut (
    .clk                   (clk),
    .reset_N               (reset_N),
    .frame_num             (frame_num),
    .num_of_history_frames (num_of_history_frames),
    .start_write           (start_write),
    .line_valid            (line_valid),
    .data_in               (data_in),
    .frame_end             (frame_end),
    .ready_out             (ready_out),
    .we                    (we),
    .wr_slot               (wr_slot),
    .wr_addr               (wr_addr),
    .data_out              (data_out),
    .end_pointers          (end_pointers),
`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
    .overflow              (overflow),
    .dropped_cnt           (dropped_cnt),
`endif
    .busy                  (busy),
    .done_write            (done_write)
  );

  typedef struct {
    logic [SW-1:0] slot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_q[$];
  int unsigned model_ptr[NS];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ptr_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < int'(NS); i++) v[i*AW +: AW] = AW'(model_ptr[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_N && we) got_q.push_back('{wr_slot, wr_addr, data_out});
  end

  task automatic run_frame(input int unsigned fnum, input int unsigned hist, input int unsigned n,
                           input bit end_with_last, input bit poke_start);
    int unsigned slot, m_cnt, m_drop, nchk;
    bit          m_ovf, exp_ready, ended;
    logic [DW-1:0] d;
    slot   = fnum % ((hist == 0) ? 1 : hist);
    m_cnt  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    ended  = 1'b0;
    exp_q.delete();
    got_q.delete();
    frame_num             = FW'(fnum);
    num_of_history_frames = HW'(hist);
    start_write           = 1'b1;
    tick();
    start_write = 1'b0;
    check("busy_open", 64'(busy), 64'(1));
    check("ptrs_hold", 64'(end_pointers), ptr_vec());
    for (int i = 0; i < int'(n); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        line_valid = 1'b0;
        tick();
      end
      d          = {$urandom, $urandom};
      line_valid = 1'b1;
      data_in    = d;
      frame_end  = end_with_last && (i == int'(n) - 1);
      ended      = frame_end;
      if (poke_start && i == 0) begin
        start_write           = 1'b1;
        frame_num             = FW'(fnum + 3);
        num_of_history_frames = HW'(3);
      end
      exp_ready = DropEn ? 1'b1 : (m_cnt < CAP);
      check("ready", 64'(ready_out), 64'(exp_ready));
      tick();
      start_write = 1'b0;
      if (exp_ready) begin
        if (m_cnt < CAP) begin
          exp_q.push_back('{SW'(slot), AW'(m_cnt), d});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < CAP) m_drop++;
        end
      end
    end
    line_valid = 1'b0;
    if (!ended) begin
      frame_end = 1'b1;
      tick();
    end
    frame_end = 1'b0;
    // Commit cycle: pointers must still show the previous values.
    check("commit_done", 64'(done_write), 64'(0));
    check("commit_ptrs", 64'(end_pointers), ptr_vec());
    model_ptr[slot] = m_cnt;
    tick();
    check("done", 64'(done_write), 64'(1));
    check("done_ptrs", 64'(end_pointers), ptr_vec());
`ifdef OFLOW_WRITE_OVERFLOW_DROP_EN
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("dropped", 64'(dropped_cnt), 64'(m_drop));
`endif
    tick();
    check("idle_done", 64'(done_write), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < int'(nchk); i++) begin
      check("wr_slot_addr", 64'({got_q[i].slot, got_q[i].addr}),
            64'({exp_q[i].slot, exp_q[i].addr}));
      check("wr_data", got_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < int'(NS); i++) model_ptr[i] = 0;
    #12;
    check("rst_ready", 64'(ready_out), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done_write), 64'(0));
    check("rst_ptrs", 64'(end_pointers), 64'(0));
    check("rst_wr", 64'({wr_slot, wr_addr}), 64'(0));
    check("rst_data", data_out, 64'(0));
    @(posedge clk);
    #1;
    reset_N = 1'b1;

    // frame_end while idle is ignored
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("idle_fe_busy", 64'(busy), 64'(0));
    tick();
    check("idle_fe_done", 64'(done_write), 64'(0));

    run_frame(7, 5, 3, 1'b1, 1'b0);
    for (int f = 0; f < 7; f++) run_frame(f, 5, 4, f[0], 1'b0);
    run_frame(3, 3, 0, 1'b0, 1'b0);
    run_frame(9, 5, 20, 1'b1, 1'b0);
    run_frame(12, 4, 5, 1'b0, 1'b1);

    // Reset in the middle of a frame
    frame_num             = FW'(2);
    num_of_history_frames = HW'(5);
    start_write           = 1'b1;
    tick();
    start_write = 1'b0;
    line_valid  = 1'b1;
    data_in     = 64'h1111;
    tick();
    data_in = 64'h2222;
    tick();
    line_valid = 1'b0;
    tick();
    reset_N = 1'b0;
    #2;
    check("mrst_we", 64'(we), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_ready", 64'(ready_out), 64'(0));
    check("mrst_ptrs", 64'(end_pointers), 64'(0));
    check("mrst_wr", 64'({wr_slot, wr_addr}), 64'(0));
    for (int i = 0; i < int'(NS); i++) model_ptr[i] = 0;
    @(posedge clk);
    #1;
    reset_N = 1'b1;
    run_frame(2, 5, 3, 1'b1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_frame($urandom_range(0, 255), $urandom_range(0, 5), $urandom_range(0, 20),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
